mini16sc_dbus_responder: RTL and testbench

- Responder on the mini16sc data-memory bus: accepts the CPU's read address, write address, write data and write enable; returns registered read data.
- Decodes the low (2^DEPTH_D - 8) words as data RAM and the top 8 words as MMIO registers.
- MMIO provides a TX stream FIFO, an RX stream FIFO, a free-running cycle counter with snapshot, and a control register driving the CPU soft_reset.
- Sits between the CPU and the SoC top; its stream ports connect to a UART or host bridge.

---
 rtl/mini16sc_dbus_responder.sv | 210 +++++++++++++++++++++
 tb/tb_mini16sc_dbus_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini16sc_dbus_responder.sv
// mini16sc data-bus responder: data RAM in the low words, MMIO in the top eight
// words (TX/RX stream FIFOs, cycle counter with snapshot, soft-reset control).
module mini16sc_dbus_responder #(
    parameter int unsigned WIDTH_D    = 16,
    parameter int unsigned DEPTH_D    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DEPTH_D-1:0] mem_d_r_addr,
    output logic [WIDTH_D-1:0] mem_d_r_data,
    input  logic [DEPTH_D-1:0] mem_d_w_addr,
    input  logic [WIDTH_D-1:0] mem_d_w_data,
    input  logic               mem_d_we,
    output logic [WIDTH_D-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [WIDTH_D-1:0] rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               soft_reset
);

    localparam int unsigned RAM_WORDS    = (1 << DEPTH_D) - 8;
    localparam int unsigned FIFO_ENTRIES = 1 << FIFO_DEPTH;
    localparam int unsigned CNT_W        = FIFO_DEPTH + 1;

    typedef logic [FIFO_DEPTH-1:0] ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [2*WIDTH_D-1:0]  cyc_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(FIFO_ENTRIES);
    localparam cyc_t CYC_ONE  = cyc_t'(1);

    localparam logic [2:0] OFF_TX_DATA   = 3'd0;
    localparam logic [2:0] OFF_TX_STATUS = 3'd1;
    localparam logic [2:0] OFF_RX_DATA   = 3'd2;
    localparam logic [2:0] OFF_RX_POP    = 3'd3;
    localparam logic [2:0] OFF_RX_STATUS = 3'd4;
    localparam logic [2:0] OFF_CYC_LO    = 3'd5;
    localparam logic [2:0] OFF_CYC_HI    = 3'd6;
    localparam logic [2:0] OFF_CTRL      = 3'd7;

    function automatic logic [WIDTH_D-1:0] status_word(input logic full, input logic empty,
                                                       input logic ovf, input cnt_t cnt);
        logic [WIDTH_D-1:0] s;
        s              = '0;
        s[0]           = full;
        s[1]           = empty;
        s[2]           = ovf;
        s[CNT_W+7:8]   = cnt;
        return s;
    endfunction

    // Address decode: the top eight words of the space are MMIO.
    logic       r_mmio, w_mmio;
    logic [2:0] r_off, w_off;
    logic       ram_we, tx_data_we, tx_status_we, rx_pop_we, rx_status_we, ctrl_we;

    assign r_mmio       = &mem_d_r_addr[DEPTH_D-1:3];
    assign w_mmio       = &mem_d_w_addr[DEPTH_D-1:3];
    assign r_off        = mem_d_r_addr[2:0];
    assign w_off        = mem_d_w_addr[2:0];
    assign ram_we       = mem_d_we & ~w_mmio;
    assign tx_data_we   = mem_d_we & w_mmio & (w_off == OFF_TX_DATA);
    assign tx_status_we = mem_d_we & w_mmio & (w_off == OFF_TX_STATUS);
    assign rx_pop_we    = mem_d_we & w_mmio & (w_off == OFF_RX_POP);
    assign rx_status_we = mem_d_we & w_mmio & (w_off == OFF_RX_STATUS);
    assign ctrl_we      = mem_d_we & w_mmio & (w_off == OFF_CTRL);

    logic [WIDTH_D-1:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (ram_we) ram[mem_d_w_addr] <= mem_d_w_data;
    end

    // TX FIFO: CPU pushes, stream sink pops.
    logic [WIDTH_D-1:0] tx_mem [FIFO_ENTRIES];
    ptr_t               tx_wr_ptr_q, tx_rd_ptr_q;
    cnt_t               tx_count_q, tx_count_d;
    logic               tx_ovf_q, tx_ovf_d;
    logic               tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_count_q == CNT_FULL);
    assign tx_empty = (tx_count_q == '0);
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr_q];
    assign tx_pop   = tx_valid & tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_push  = tx_data_we & (~tx_full | tx_pop);

    always_comb begin
        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop)      tx_count_d = tx_count_q + CNT_ONE;
        else if (!tx_push && tx_pop) tx_count_d = tx_count_q - CNT_ONE;
        tx_ovf_d = tx_ovf_q;
        if (tx_status_we)             tx_ovf_d = 1'b0;
        if (tx_data_we && !tx_push)   tx_ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= mem_d_w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            tx_ovf_q    <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_ONE;
            tx_count_q <= tx_count_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end

    // RX FIFO: stream source pushes, CPU pops through RX_POP.
    logic [WIDTH_D-1:0] rx_mem [FIFO_ENTRIES];
    ptr_t               rx_wr_ptr_q, rx_rd_ptr_q;
    cnt_t               rx_count_q, rx_count_d;
    logic               rx_ovf_q, rx_ovf_d;
    logic               rx_full, rx_empty, rx_push, rx_pop;
    logic [WIDTH_D-1:0] rx_head;

    assign rx_full  = (rx_count_q == CNT_FULL);
    assign rx_empty = (rx_count_q == '0);
    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rx_pop_we & ~rx_empty;
    assign rx_head  = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];

    always_comb begin
        rx_count_d = rx_count_q;
        if (rx_push && !rx_pop)      rx_count_d = rx_count_q + CNT_ONE;
        else if (!rx_push && rx_pop) rx_count_d = rx_count_q - CNT_ONE;
        rx_ovf_d = rx_ovf_q;
        if (rx_status_we)        rx_ovf_d = 1'b0;
        if (rx_valid && rx_full) rx_ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            rx_ovf_q    <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_ONE;
            rx_count_q <= rx_count_d;
            rx_ovf_q   <= rx_ovf_d;
        end
    end

    // Cycle counter, snapshot and control.
    cyc_t cyc_q, snap_q;
    logic soft_reset_q;

    assign soft_reset = soft_reset_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q        <= '0;
            snap_q       <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            cyc_q <= cyc_q + CYC_ONE;
            if (ctrl_we) begin
                soft_reset_q <= mem_d_w_data[0];
                if (mem_d_w_data[1]) snap_q <= cyc_q;
            end
        end
    end

    // Read mux sees state from before this edge, giving read-before-write everywhere.
    logic [WIDTH_D-1:0] r_data_d;

    always_comb begin
        r_data_d = '0;
        if (!r_mmio) begin
            r_data_d = ram[mem_d_r_addr];
        end else begin
            case (r_off)
                OFF_TX_DATA:   r_data_d = '0;
                OFF_TX_STATUS: r_data_d = status_word(tx_full, tx_empty, tx_ovf_q, tx_count_q);
                OFF_RX_DATA:   r_data_d = rx_head;
                OFF_RX_POP:    r_data_d = '0;
                OFF_RX_STATUS: r_data_d = status_word(rx_full, rx_empty, rx_ovf_q, rx_count_q);
                OFF_CYC_LO:    r_data_d = snap_q[WIDTH_D-1:0];
                OFF_CYC_HI:    r_data_d = snap_q[2*WIDTH_D-1:WIDTH_D];
                OFF_CTRL:      r_data_d = {{(WIDTH_D-1){1'b0}}, soft_reset_q};
                default:       r_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mem_d_r_data <= '0;
        else       mem_d_r_data <= r_data_d;
    end

endmodule

// File: tb/tb_mini16sc_dbus_responder.sv
// Self-checking bench for mini16sc_dbus_responder: scoreboard queues for read data
// and TX stream output, one task per feature.
module tb_mini16sc_dbus_responder;

    localparam logic [7:0] TXD  = 8'hF8;
    localparam logic [7:0] TXS  = 8'hF9;
    localparam logic [7:0] RXD  = 8'hFA;
    localparam logic [7:0] RXP  = 8'hFB;
    localparam logic [7:0] RXS  = 8'hFC;
    localparam logic [7:0] CLO  = 8'hFD;
    localparam logic [7:0] CHI  = 8'hFE;
    localparam logic [7:0] CTRL = 8'hFF;

    logic        clk, reset;
    logic [7:0]  r_addr, w_addr;
    logic [15:0] r_data, w_data, tx_data, rx_data;
    logic        we, tx_valid, tx_ready, rx_valid, rx_ready, soft_reset;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] rd_sb[$];
    logic [15:0] tx_sb[$];
    logic [15:0] rx_sb[$];
    logic [31:0] cyc_model = '0;
    logic [15:0] exp;

    mini16sc_dbus_responder dut (
        .clk          (clk),
        .reset        (reset),
        .mem_d_r_addr (r_addr),
        .mem_d_r_data (r_data),
        .mem_d_w_addr (w_addr),
        .mem_d_w_data (w_data),
        .mem_d_we     (we),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .soft_reset   (soft_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        logic r;
        r = reset;
        @(posedge clk);
        if (r) cyc_model = '0;
        else   cyc_model = cyc_model + 32'd1;
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        w_addr = a; w_data = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic issue_rd(input logic [7:0] a, input logic [15:0] e);
        r_addr = a;
        rd_sb.push_back(e);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        r_addr = '0; w_addr = '0; w_data = '0; rx_data = '0;
        step(); step();
        checks++; if (r_data !== 16'h0) $display("FAIL rst_rdata: got %h expected 0000", r_data); else passes++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); else passes++;
        checks++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready: got %b expected 1", rx_ready); else passes++;
        checks++; if (soft_reset !== 1'b0) $display("FAIL rst_soft_reset: got %b expected 0", soft_reset); else passes++;
        reset = 1'b0;
        issue_rd(TXS, 16'h0002); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rst_txs: got %h expected %h", r_data, exp); else passes++;
        issue_rd(RXS, 16'h0002); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rst_rxs: got %h expected %h", r_data, exp); else passes++;
        issue_rd(CHI, 16'h0000); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rst_snap: got %h expected %h", r_data, exp); else passes++;
    endtask

    task automatic test_ram();
        wr(8'h10, 16'h1234);
        issue_rd(8'h10, 16'h1234); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL ram_rd: got %h expected %h", r_data, exp); else passes++;
        // Same-edge write and read of one address returns the old word.
        w_addr = 8'h10; w_data = 16'h5678; we = 1'b1;
        issue_rd(8'h10, 16'h1234); we = 1'b0; exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL ram_rbw: got %h expected %h", r_data, exp); else passes++;
        issue_rd(8'h10, 16'h5678); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL ram_new: got %h expected %h", r_data, exp); else passes++;
        for (int i = 0; i < 6; i++) wr(8'(i * 47 + 3), 16'(16'hA5C3 ^ (i * 16'h1111)));
        wr(8'hF7, 16'h7E57);
        for (int i = 0; i < 6; i++) begin
            issue_rd(8'(i * 47 + 3), 16'(16'hA5C3 ^ (i * 16'h1111))); exp = rd_sb.pop_front();
            checks++; if (r_data !== exp) $display("FAIL ram_pat%0d: got %h expected %h", i, r_data, exp); else passes++;
        end
        issue_rd(8'hF7, 16'h7E57); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL ram_top: got %h expected %h", r_data, exp); else passes++;
    endtask

    task automatic drain_tx(input string name);
        tx_ready = 1'b1;
        for (int g = 0; g < 40 && tx_sb.size() > 0; g++) begin
            exp = tx_sb.pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp)
                $display("FAIL %s_data: got %b/%h expected 1/%h", name, tx_valid, tx_data, exp);
            else passes++;
            step();
        end
        checks++; if (tx_sb.size() != 0) $display("FAIL %s_timeout: got %0d left expected 0", name, tx_sb.size()); else passes++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL %s_empty: got %b expected 0", name, tx_valid); else passes++;
        tx_ready = 1'b0;
    endtask

    task automatic test_tx();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(TXD, 16'(i));
            tx_sb.push_back(16'(i));
        end
        wr(TXD, 16'hAAAA);
        issue_rd(TXS, 16'h1005); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL tx_full_ovf: got %h expected %h", r_data, exp); else passes++;
        issue_rd(TXD, 16'h0000); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL tx_data_rd: got %h expected %h", r_data, exp); else passes++;
        drain_tx("tx");
        issue_rd(TXS, 16'h0006); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL tx_ovf_sticky: got %h expected %h", r_data, exp); else passes++;
        wr(TXS, 16'h0000);
        issue_rd(TXS, 16'h0002); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL tx_ovf_clr: got %h expected %h", r_data, exp); else passes++;
    endtask

    task automatic test_rx();
        rx_valid = 1'b1; rx_data = 16'hBEEF; step();
        rx_data = 16'hCAFE; step();
        rx_valid = 1'b0;
        issue_rd(RXS, 16'h0200); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_cnt2: got %h expected %h", r_data, exp); else passes++;
        issue_rd(RXD, 16'hBEEF); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_head0: got %h expected %h", r_data, exp); else passes++;
        wr(RXP, 16'h0);
        issue_rd(RXD, 16'hCAFE); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_head1: got %h expected %h", r_data, exp); else passes++;
        wr(RXP, 16'h0);
        issue_rd(RXD, 16'h0000); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_empty_data: got %h expected %h", r_data, exp); else passes++;
        wr(RXP, 16'h0);
        issue_rd(RXS, 16'h0002); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_pop_empty: got %h expected %h", r_data, exp); else passes++;
        // Fill, then one extra beat while full sets overflow.
        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 16'(16'h0100 + i);
            if (i < 16) begin
                rx_sb.push_back(rx_data);
                checks++; if (rx_ready !== 1'b1) $display("FAIL rx_ready%0d: got %b expected 1", i, rx_ready); else passes++;
            end
            step();
        end
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) $display("FAIL rx_ready_full: got %b expected 0", rx_ready); else passes++;
        issue_rd(RXS, 16'h1005); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_full_ovf: got %h expected %h", r_data, exp); else passes++;
        wr(RXS, 16'hFFFF);
        issue_rd(RXS, 16'h1001); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_ovf_clr: got %h expected %h", r_data, exp); else passes++;
        for (int i = 0; i < 16; i++) begin
            issue_rd(RXD, rx_sb.pop_front()); exp = rd_sb.pop_front();
            checks++; if (r_data !== exp) $display("FAIL rx_order%0d: got %h expected %h", i, r_data, exp); else passes++;
            wr(RXP, 16'h0);
        end
        // Push and CPU pop on the same edge.
        rx_valid = 1'b1; rx_data = 16'h0A0A; step();
        rx_data = 16'h0B0B; w_addr = RXP; we = 1'b1; step();
        we = 1'b0; rx_valid = 1'b0;
        issue_rd(RXS, 16'h0100); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_pushpop_cnt: got %h expected %h", r_data, exp); else passes++;
        issue_rd(RXD, 16'h0B0B); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rx_pushpop_head: got %h expected %h", r_data, exp); else passes++;
        wr(RXP, 16'h0);
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(TXD, 16'(16'h0200 + i));
            tx_sb.push_back(16'(16'h0200 + i));
        end
        // Sink pops the head while the CPU pushes into the full FIFO.
        exp = tx_sb.pop_front();
        checks++; if (tx_data !== exp) $display("FAIL b2b_head: got %h expected %h", tx_data, exp); else passes++;
        tx_ready = 1'b1; w_addr = TXD; w_data = 16'h5555; we = 1'b1;
        step();
        we = 1'b0; tx_ready = 1'b0;
        tx_sb.push_back(16'h5555);
        issue_rd(TXS, 16'h1001); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL b2b_status: got %h expected %h", r_data, exp); else passes++;
        drain_tx("b2b");
    endtask

    task automatic test_ctrl_reset();
        wr(CTRL, 16'h0001);
        checks++; if (soft_reset !== 1'b1) $display("FAIL ctrl_set: got %b expected 1", soft_reset); else passes++;
        issue_rd(CTRL, 16'h0001); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL ctrl_rd: got %h expected %h", r_data, exp); else passes++;
        wr(CTRL, 16'h0000);
        checks++; if (soft_reset !== 1'b0) $display("FAIL ctrl_clr: got %b expected 0", soft_reset); else passes++;
        wr(CTRL, 16'h0001);
        wr(TXD, 16'h0077);
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin rx_data = 16'(16'h0300 + i); step(); end
        rx_valid = 1'b0;
        checks++; if (tx_valid !== 1'b1 || rx_ready !== 1'b0)
            $display("FAIL prerst_fifos: got %b/%b expected 1/0", tx_valid, rx_ready); else passes++;
        r_addr = TXS; reset = 1'b1; step(); reset = 1'b0;
        checks++; if (tx_valid !== 1'b0) $display("FAIL rst2_tx_valid: got %b expected 0", tx_valid); else passes++;
        checks++; if (rx_ready !== 1'b1) $display("FAIL rst2_rx_ready: got %b expected 1", rx_ready); else passes++;
        checks++; if (r_data !== 16'h0) $display("FAIL rst2_rdata: got %h expected 0000", r_data); else passes++;
        checks++; if (soft_reset !== 1'b0) $display("FAIL rst2_soft_reset: got %b expected 0", soft_reset); else passes++;
        issue_rd(RXS, 16'h0002); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL rst2_rxs: got %h expected %h", r_data, exp); else passes++;
    endtask

    task automatic test_counter();
        logic [31:0] exp_snap;
        reset = 1'b1; step(); reset = 1'b0;
        repeat (99) step();
        wr(CTRL, 16'h0002);
        checks++; if (soft_reset !== 1'b0) $display("FAIL snap_no_sr: got %b expected 0", soft_reset); else passes++;
        issue_rd(CLO, 16'd99); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL snap_lo: got %h expected %h", r_data, exp); else passes++;
        issue_rd(CHI, 16'd0); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL snap_hi: got %h expected %h", r_data, exp); else passes++;
        repeat (65536) step();
        exp_snap = cyc_model;
        wr(CTRL, 16'h0002);
        issue_rd(CLO, exp_snap[15:0]); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL snap2_lo: got %h expected %h", r_data, exp); else passes++;
        issue_rd(CHI, 16'd1); exp = rd_sb.pop_front();
        checks++; if (r_data !== exp) $display("FAIL snap2_hi: got %h expected %h", r_data, exp); else passes++;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx();
        test_rx();
        test_back_to_back();
        test_ctrl_reset();
        test_counter();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
